// File: rtl/vlog_statmchs_sum3_drv.sv
// Drives a three-operand summer: accepts a packed operand set, feeds one operand per clock with
// start held high, waits for ready, then presents the captured sum (optional self-check: SUM3_DRV_SELFCHECK_EN).
module vlog_statmchs_sum3_drv #(
    parameter int WIDTH   = 8,
    parameter int NOPS    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NOPS*WIDTH-1:0] in_ops,
    output logic                  start,
    output logic [WIDTH-1:0]      d,
    input  logic [WIDTH-1:0]      sum_in,
    input  logic                  ready_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_timeout,
    output logic                  res_mismatch
);
    localparam int KW = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic [WIDTH-1:0] ops_q [NOPS];
    logic [WIDTH-1:0] d_nxt, res_sum_nxt;
    logic             in_ready_nxt, start_nxt, res_valid_nxt, res_timeout_nxt, res_mismatch_nxt;
    logic             accept, capture, expire, fault;

    assign accept  = (state == IDLE) && in_valid && in_ready;
    // The summer has not seen start fall yet on the first WAIT cycle, so its ready is stale there.
    assign capture = (state == WAIT) && (tcnt != '0) && ready_in;
    assign expire  = (state == WAIT) && !capture && (tcnt == TW'(TIMEOUT - 1));

`ifdef SUM3_DRV_SELFCHECK_EN
    logic [WIDTH-1:0] exp_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            exp_sum <= '0;
        else if (accept)
            exp_sum <= '0;
        else if (state == FEED)
            exp_sum <= exp_sum + d;
    end

    assign fault = capture ? (sum_in != exp_sum) : 1'b1;

    always_ff @(posedge clk) begin
        if ((capture && (sum_in != exp_sum)) || expire)
            $display("sum3_drv mismatch: expected %0d actual %0d timeout %0b",
                     exp_sum, capture ? sum_in : '0, expire);
    end
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        k_nxt            = k;
        tcnt_nxt         = tcnt;
        in_ready_nxt     = 1'b0;
        start_nxt        = 1'b0;
        d_nxt            = d;
        res_valid_nxt    = res_valid;
        res_sum_nxt      = res_sum;
        res_timeout_nxt  = res_timeout;
        res_mismatch_nxt = res_mismatch;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FEED;
                    start_nxt = 1'b1;
                    d_nxt     = in_ops[WIDTH-1:0];
                    k_nxt     = '0;
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            FEED: begin
                if (k == KW'(NOPS - 1)) begin
                    state_nxt = WAIT;
                    tcnt_nxt  = '0;
                end else begin
                    start_nxt = 1'b1;
                    k_nxt     = k + KW'(1);
                    d_nxt     = ops_q[k + KW'(1)];
                end
            end
            WAIT: begin
                if (capture) begin
                    state_nxt        = DONE;
                    res_valid_nxt    = 1'b1;
                    res_sum_nxt      = sum_in;
                    res_timeout_nxt  = 1'b0;
                    res_mismatch_nxt = fault;
                end else if (expire) begin
                    state_nxt        = DONE;
                    res_valid_nxt    = 1'b1;
                    res_sum_nxt      = '0;
                    res_timeout_nxt  = 1'b1;
                    res_mismatch_nxt = fault;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt     = IDLE;
                    res_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            tcnt         <= '0;
            in_ready     <= 1'b0;
            start        <= 1'b0;
            d            <= '0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_timeout  <= 1'b0;
            res_mismatch <= 1'b0;
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            tcnt         <= tcnt_nxt;
            in_ready     <= in_ready_nxt;
            start        <= start_nxt;
            d            <= d_nxt;
            res_valid    <= res_valid_nxt;
            res_sum      <= res_sum_nxt;
            res_timeout  <= res_timeout_nxt;
            res_mismatch <= res_mismatch_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NOPS; i++)
                ops_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NOPS; i++)
                ops_q[i] <= in_ops[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_vlog_statmchs_sum3_drv.sv
// Directed and randomized bench for vlog_statmchs_sum3_drv with a behavioural summer and
// an arithmetic reference for every result.
module tb_vlog_statmchs_sum3_drv;
`ifdef SUM3_DRV_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_ops = '0;
    logic        start;
    logic [7:0]  d;
    logic [7:0]  sum_in = '0;
    logic        ready_in = 1'b1;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_sum;
    logic        res_timeout;
    logic        res_mismatch;

    int errors = 0;
    int checks = 0;

    // Summer behaviour knobs
    bit         sm_hang  = 1'b0;
    bit         sm_stale = 1'b0;
    logic [7:0] sm_err   = '0;
    logic [7:0] acc      = '0;
    logic       prev_start = 1'b0;

    always #5 clk = ~clk;

    vlog_statmchs_sum3_drv #(.WIDTH(8), .NOPS(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
        .start(start), .d(d), .sum_in(sum_in), .ready_in(ready_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_timeout(res_timeout), .res_mismatch(res_mismatch)
    );

    // Summer: sums d while start is high, answers one cycle after start falls.
    // In stale mode ready never drops and sum lags the accumulator by a cycle.
    always @(posedge clk) begin
        prev_start <= start;
        if (start)
            acc <= prev_start ? acc + d : d;
        if (sm_stale) begin
            ready_in <= 1'b1;
            sum_in   <= acc;
        end else if (start) begin
            ready_in <= 1'b0;
        end else if (prev_start && !sm_hang) begin
            ready_in <= 1'b1;
            sum_in   <= acc + sm_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a triple at a negedge; returns at the negedge of the first FEED cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int n = 0;
        in_ops   = {c, b, a};
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 50, 1);
        @(negedge clk);
    endtask

    // From FEED cycle 0: checks operand stream and result; leaves the result undrained.
    task automatic feed_collect(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int          m = 0;
        int          exp_wait;
        logic [7:0]  exp_sum;
        logic        exp_to;
        logic        exp_mis;
        in_ops = 24'($urandom);
        check("feed0_start", start, 1);
        check("feed0_d", d, a);
        check("feed_in_ready", in_ready, 0);
        @(negedge clk);
        check("feed1_start", start, 1);
        check("feed1_d", d, b);
        @(negedge clk);
        in_valid = 1'b0;
        check("feed2_start", start, 1);
        check("feed2_d", d, c);
        @(negedge clk);
        check("wait_start_low", start, 0);
        check("wait_d_hold", d, c);
        while (!res_valid && m < 40) begin
            @(negedge clk);
            m++;
        end
        exp_to   = sm_hang;
        exp_wait = sm_hang ? 16 : 2;
        exp_sum  = sm_hang ? 8'd0 : 8'((int'(a) + int'(b) + int'(c)) % 256 + int'(sm_err));
        exp_mis  = (sm_hang || sm_err != 0) ? SC : 1'b0;
        check("wait_cycles", m, exp_wait);
        check("res_sum", res_sum, exp_sum);
        check("res_timeout", res_timeout, exp_to);
        check("res_mismatch", res_mismatch, exp_mis);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("drain_valid_low", res_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a, b, c);
        feed_collect(a, b, c);
        drain();
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] ra, rb, rc;

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_start", start, 0);
        check("rst_d", d, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_res_mismatch", res_mismatch, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        txn(8'd10, 8'd20, 8'd30);
        txn(8'd200, 8'd100, 8'd1);

        sm_hang = 1'b1;
        txn(8'd5, 8'd6, 8'd7);
        sm_hang = 1'b0;

        sm_err = 8'hFF;
        txn(8'd10, 8'd20, 8'd30);
        sm_err = 8'd0;

        // First WAIT cycle shows a partial sum with ready high; it must be skipped.
        sm_stale = 1'b1;
        txn(8'd11, 8'd22, 8'd33);
        sm_stale = 1'b0;

        // Back-pressure with a new triple waiting
        send(8'd40, 8'd50, 8'd60);
        feed_collect(8'd40, 8'd50, 8'd60);
        held     = res_sum;
        in_ops   = {8'd9, 8'd8, 8'd7};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_stable", res_sum, held);
            check("bp_start", start, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_drop_valid", res_valid, 0);
        check("bp_drop_in_ready", in_ready, 1);
        @(negedge clk);
        feed_collect(8'd7, 8'd8, 8'd9);
        drain();

        // Reset on the second operand cycle
        send(8'd90, 8'd91, 8'd92);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_start", start, 0);
        check("mid_rst_d", d, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_in_ready0", in_ready, 0);
        @(negedge clk);
        check("post_rst_in_ready1", in_ready, 1);
        txn(8'd1, 8'd2, 8'd3);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            sm_err = (i == 3) ? 8'($urandom_range(1, 255)) : 8'd0;
            txn(ra, rb, rc);
        end
        sm_err = 8'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
